// File: rtl/gpio_cfg_pkg.sv
// Shared types and sizing helpers for the GPIO pad-chain configuration loader.
package gpio_cfg_pkg;

    localparam int DEFAULT_PAD_CTRL_BITS = 12;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        DONE
    } state_e;

    function automatic int calc_nb(input int npads, input int bits);
        return npads * bits;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_cfg_regbank.sv
// Per-pad configuration word storage with write qualification, error pulse,
// combinational readback and a flat snapshot for the serial shifter.
module gpio_cfg_regbank
    import gpio_cfg_pkg::*;
#(
    parameter int                       NPADS         = 9,
    parameter int                       PAD_CTRL_BITS = DEFAULT_PAD_CTRL_BITS,
    parameter logic [PAD_CTRL_BITS-1:0] DEFAULT_CFG   = 12'hC00,
    parameter int                       AW            = $clog2(NPADS)
) (
    input  logic                                        mclk,
    input  logic                                        resetn,
    input  logic                                        idle,
    input  logic                                        cfg_wr,
    input  logic [AW-1:0]                               cfg_addr,
    input  logic [PAD_CTRL_BITS-1:0]                    cfg_wdata,
    output logic [PAD_CTRL_BITS-1:0]                    cfg_rdata,
    output logic                                        cfg_err,
    output logic [calc_nb(NPADS, PAD_CTRL_BITS)-1:0]    snapshot
);

    localparam logic [AW:0] NPADS_W = (AW+1)'(NPADS);

    logic [PAD_CTRL_BITS-1:0] words_q [NPADS];
    logic                     err_q;
    logic                     addr_ok;
    logic                     wr_ok;

    assign addr_ok = ({1'b0, cfg_addr} < NPADS_W);
    assign wr_ok   = cfg_wr && idle && addr_ok;

    always_ff @(posedge mclk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NPADS; k++) begin
                words_q[k] <= DEFAULT_CFG;
            end
            err_q <= 1'b0;
        end else begin
            err_q <= cfg_wr && !wr_ok;
            if (wr_ok) begin
                words_q[cfg_addr] <= cfg_wdata;
            end
        end
    end

    always_comb begin
        cfg_rdata = '0;
        if (addr_ok) begin
            cfg_rdata = words_q[cfg_addr];
        end
    end

    // Word k occupies slice k, so the top slice belongs to the last pad.
    for (genvar k = 0; k < NPADS; k++) begin : g_snap
        assign snapshot[k*PAD_CTRL_BITS +: PAD_CTRL_BITS] = words_q[k];
    end

    assign cfg_err = err_q;

endmodule

// File: rtl/gpio_cfg_loader.sv
// Serial configuration master for the GPIO pad chain.
// Optional GPIO_CFG_AUTOLOAD_EN: push the stored words into the chain right after reset.
module gpio_cfg_loader
    import gpio_cfg_pkg::*;
#(
    parameter int                       NPADS         = 9,
    parameter int                       PAD_CTRL_BITS = DEFAULT_PAD_CTRL_BITS,
    parameter int                       CLK_DIV       = 4,
    parameter logic [PAD_CTRL_BITS-1:0] DEFAULT_CFG   = 12'hC00,
    parameter int                       AW            = $clog2(NPADS)
) (
    input  logic                     mclk,
    input  logic                     resetn,
    input  logic                     cfg_wr,
    input  logic [AW-1:0]            cfg_addr,
    input  logic [PAD_CTRL_BITS-1:0] cfg_wdata,
    output logic [PAD_CTRL_BITS-1:0] cfg_rdata,
    output logic                     cfg_err,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     serial_clock,
    output logic                     serial_data,
    output logic                     serial_load
);

    localparam int NB = calc_nb(NPADS, PAD_CTRL_BITS);
    localparam int BW = cnt_width(NB + 1);
    localparam int PW = cnt_width(CLK_DIV);
    localparam logic [BW-1:0] LAST_BIT   = BW'(NB - 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(CLK_DIV - 1);

    state_e          state_q;
    logic [NB-1:0]   shreg_q;
    logic [BW-1:0]   bit_q;
    logic [PW-1:0]   phase_q;
    logic            sclk_q;
    logic            sload_q;
    logic            busy_q;
    logic            done_q;
    logic [NB-1:0]   snapshot;
    logic            idle;
    logic            start_go;
    logic            phase_last;

    assign idle       = (state_q == IDLE);
    assign phase_last = (phase_q == LAST_PHASE);

    gpio_cfg_regbank #(
        .NPADS         (NPADS),
        .PAD_CTRL_BITS (PAD_CTRL_BITS),
        .DEFAULT_CFG   (DEFAULT_CFG),
        .AW            (AW)
    ) u_regbank (
        .mclk      (mclk),
        .resetn    (resetn),
        .idle      (idle),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .cfg_err   (cfg_err),
        .snapshot  (snapshot)
    );

`ifdef GPIO_CFG_AUTOLOAD_EN
    logic autoload_q;

    // Pending self-start armed by reset, consumed by the first accepted start.
    always_ff @(posedge mclk or negedge resetn) begin
        if (!resetn) begin
            autoload_q <= 1'b1;
        end else if (start_go) begin
            autoload_q <= 1'b0;
        end
    end

    assign start_go = idle && !cfg_wr && (start || autoload_q);
`else
    assign start_go = idle && !cfg_wr && start;
`endif

    // The shift register MSB is the serial data line, so data is always a flop output.
    always_ff @(posedge mclk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            phase_q <= '0;
            sclk_q  <= 1'b0;
            sload_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_go) begin
                        shreg_q <= snapshot;
                        bit_q   <= '0;
                        phase_q <= '0;
                        sclk_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (phase_last) begin
                        phase_q <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= SHIFT_HI;
                    end else begin
                        phase_q <= phase_q + PW'(1);
                    end
                end
                SHIFT_HI: begin
                    if (phase_last) begin
                        phase_q <= '0;
                        sclk_q  <= 1'b0;
                        if (bit_q == LAST_BIT) begin
                            sload_q <= 1'b1;
                            state_q <= LOAD;
                        end else begin
                            bit_q   <= bit_q + BW'(1);
                            shreg_q <= {shreg_q[NB-2:0], 1'b0};
                            state_q <= SHIFT_LO;
                        end
                    end else begin
                        phase_q <= phase_q + PW'(1);
                    end
                end
                LOAD: begin
                    if (phase_last) begin
                        phase_q <= '0;
                        sload_q <= 1'b0;
                        shreg_q <= '0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        phase_q <= phase_q + PW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign serial_clock = sclk_q;
    assign serial_data  = shreg_q[NB-1];
    assign serial_load  = sload_q;

endmodule
